// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - full-duplex SPI master shift engine
// Generates SCLK from clk with a programmable divider; supports CPOL/CPHA modes and bit ordering.
module spi_shift_engine #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1),
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CNT_W-1:0]  len,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [CNT_W-1:0]  r_len;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [CNT_W:0]    r_half;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_lsb;

  // Position in the word of transfer bit b, given the ordering and length.
  function automatic logic [IDX_W-1:0] f_idx(input logic lsb, input logic [CNT_W-1:0] n,
                                             input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] v;
    v = lsb ? b : (n - b - CNT_W'(1));
    return v[IDX_W-1:0];
  endfunction

  logic [CNT_W-1:0]  w_len_in;
  logic [IDX_W-1:0]  w_idx_first;
  logic [CNT_W-1:0]  w_bit;
  logic [IDX_W-1:0]  w_idx_cur;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [CNT_W:0]    w_half_last;
  logic              w_tick;
  logic              w_lead;
  logic              w_last;
  logic              w_sample;
  logic              w_drive_lead;
  logic              w_drive_trail;
  logic [DATA_W-1:0] w_rx_next;

  assign w_len_in      = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
  assign w_idx_first   = f_idx(lsb_first, w_len_in, '0);
  assign w_bit         = r_half[CNT_W:1];
  assign w_idx_cur     = f_idx(r_lsb, r_len, w_bit);
  assign w_idx_nxt     = f_idx(r_lsb, r_len, w_bit + CNT_W'(1));
  assign w_half_last   = {r_len, 1'b0} - (CNT_W+1)'(1);
  assign w_tick        = (r_div_cnt == r_div);
  assign w_lead        = ~r_half[0];
  assign w_last        = w_tick && (r_half == w_half_last);
  assign w_sample      = w_tick && (w_lead != r_cpha);
  assign w_drive_lead  = w_tick && w_lead && r_cpha;
  // In CPHA=0 the first bit is already on mosi, so trailing edges present the following bit.
  assign w_drive_trail = w_tick && !w_lead && !r_cpha && !w_last;

  always_comb begin
    w_rx_next = r_rx;
    if (w_sample) w_rx_next[w_idx_cur] = miso;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_len     <= '0;
      r_div     <= '0;
      r_div_cnt <= '0;
      r_half    <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          sclk <= cpol;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            r_tx      <= tx_data;
            r_rx      <= '0;
            r_len     <= w_len_in;
            r_div     <= clk_div;
            r_div_cnt <= '0;
            r_half    <= '0;
            r_cpol    <= cpol;
            r_cpha    <= cpha;
            r_lsb     <= lsb_first;
            busy      <= 1'b1;
            r_state   <= S_RUN;
            if (!cpha) mosi <= tx_data[w_idx_first];
          end
        end
        S_RUN: begin
          r_rx <= w_rx_next;
          if (w_tick) begin
            r_div_cnt <= '0;
            sclk      <= ~sclk;
            r_half    <= r_half + (CNT_W+1)'(1);
            if (w_drive_lead) mosi <= r_tx[w_idx_cur];
            else if (w_drive_trail) mosi <= r_tx[w_idx_nxt];
            if (w_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              rx_data <= w_rx_next;
              r_state <= S_DONE;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          sclk    <= r_cpol;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - scoreboard bench for spi_shift_engine
// An independent SPI slave model follows sclk edges, drives miso and captures mosi.
module tb_spi_shift_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] tx_data = '0;
  logic [5:0]  len = '0;
  logic [7:0]  clk_div = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        lsb_first = 1'b0;
  logic        miso;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;
  logic        sclk;
  logic        mosi;

  spi_shift_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data), .len(len),
    .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rx;
    logic [31:0] mo;
    int          lat;
    int          edges;
    logic        last;
  } exp_t;
  exp_t sb[$];

  // Slave configuration, written only by the stimulus task.
  logic [31:0] c_word = '0;
  int          c_len = 1;
  logic        c_cpol = 1'b0;
  logic        c_cpha = 1'b0;
  logic        c_lsb = 1'b0;
  logic        c_loop = 1'b0;

  // Slave state, written only by the slave process.
  logic        s_miso = 1'b0;
  logic        s_prev = 1'b0;
  logic [31:0] s_cap = '0;
  int          s_tx_n = 0;
  int          s_rx_n = 0;
  int          s_edges = 0;

  assign miso = c_loop ? mosi : s_miso;

  function automatic logic sbit(input logic [31:0] w, input int ln, input logic lsb, input int k);
    int kk;
    kk = lsb ? k : ln - 1 - k;
    return w[kk[4:0]];
  endfunction

  always @(negedge clk) begin
    if (start && !busy && !done) begin
      s_cap   = '0;
      s_rx_n  = 0;
      s_edges = 0;
      s_tx_n  = 0;
      s_miso  = 1'b0;
      if (!c_cpha) begin
        s_miso = sbit(c_word, c_len, c_lsb, 0);
        s_tx_n = 1;
      end
    end else if (sclk !== s_prev) begin
      s_edges++;
      if ((sclk != c_cpol) != c_cpha) begin
        if (c_lsb) begin
          if (s_rx_n < 32) s_cap[s_rx_n[4:0]] = mosi;
        end else begin
          s_cap = {s_cap[30:0], mosi};
        end
        s_rx_n++;
      end else if (s_tx_n < c_len) begin
        s_miso = sbit(c_word, c_len, c_lsb, s_tx_n);
        s_tx_n++;
      end
    end
    s_prev = sclk;
  end

  // mode 0: plain transfer, 1: stray start pulses, 2: reset in bit 3
  task automatic xfer(input logic [31:0] tx, input logic [5:0] ln, input logic [7:0] dv,
                      input logic pol, input logic pha, input logic lsb,
                      input logic [31:0] sw, input logic lp, input int mode);
    int          n_eff;
    int          li;
    int          n;
    int          busy_bad;
    logic [31:0] mask;
    logic        extra;
    exp_t        e;
    n_eff = (ln == 0 || ln > 32) ? 32 : int'(ln);
    mask  = (n_eff == 32) ? 32'hFFFF_FFFF : ((32'd1 << n_eff) - 32'd1);
    li    = n_eff - 1;
    c_word = sw; c_len = n_eff; c_cpol = pol; c_cpha = pha; c_lsb = lsb; c_loop = lp;
    cpol = pol; cpha = pha; lsb_first = lsb; len = ln; clk_div = dv; tx_data = tx;
    repeat (2) @(posedge clk);
    #1;
    check("idle_sclk", 64'(sclk), 64'(pol));
    e.rx    = (lp ? tx : sw) & mask;
    e.mo    = tx & mask;
    e.lat   = 2 * n_eff * (int'(dv) + 1);
    e.edges = 2 * n_eff;
    e.last  = lsb ? tx[li[4:0]] : tx[0];
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tx_data = $urandom; len = 6'($urandom); clk_div = 8'($urandom);
    cpha = ~pha; lsb_first = ~lsb;
    n = 0;
    busy_bad = 0;
    while (!done && n < 20000) begin
      if (!busy) busy_bad++;
      if (mode == 2 && n == 7 * (int'(dv) + 1)) begin
        reset_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sclk", 64'(sclk), 64'(0));
        check("rst_mosi", 64'(mosi), 64'(0));
        check("rst_rx", 64'(rx_data), 64'(0));
        e = sb.pop_back();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        return;
      end
      start = (mode == 1 && n == 5);
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    check("done_seen", 64'(done), 64'(1));
    e = sb.pop_front();
    if (!done) return;
    check("latency", 64'(n), 64'(e.lat));
    check("busy_span", 64'(busy_bad), 64'(0));
    check("busy_at_done", 64'(busy), 64'(0));
    check("rx_data", 64'(rx_data), 64'(e.rx));
    check("sclk_at_done", 64'(sclk), 64'(pol));
    if (mode == 1) begin
      tx_data = 32'h5555_AAAA;
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_pulse", 64'(done), 64'(0));
    check("mosi_hold", 64'(mosi), 64'(e.last));
    check("slave_mosi", 64'(s_cap), 64'(e.mo));
    check("sclk_edges", 64'(s_edges), 64'(e.edges));
    if (mode == 1) begin
      extra = 1'b0;
      repeat (4) begin
        @(posedge clk);
        #1;
        extra = extra | busy | done;
      end
      check("no_requeue", 64'(extra), 64'(0));
    end
    check("rx_hold", 64'(rx_data), 64'(e.rx));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_rx", 64'(rx_data), 64'(0));
    check("reset_sclk", 64'(sclk), 64'(0));
    check("reset_mosi", 64'(mosi), 64'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    xfer(32'h0000_00A5, 6'd8, 8'd1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 0);
    xfer(32'hDEAD_BEEF, 6'd32, 8'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 0);
    xfer(32'h0000_0001, 6'd4, 8'd2, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 0);
    xfer(32'h1234_5678, 6'd0, 8'd0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 0);
    xfer(32'h8765_4321, 6'd40, 8'd1, 1'b1, 1'b0, 1'b1, 32'h0F0F_3C3C, 1'b0, 0);
    xfer(32'h0000_003C, 6'd8, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0000_005A, 1'b0, 1);
    xfer(32'h0000_00C3, 6'd8, 8'd1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 2);
    xfer(32'h0000_0096, 6'd8, 8'd1, 1'b0, 1'b1, 1'b1, 32'h0000_0069, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      xfer($urandom, 6'($urandom_range(1, 32)), 8'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
